// File: rtl/ad9361_spi_init_seq.sv
// Table-driven init sequencer for the 24-bit AD9361 SPI master: WRITE / READ_POLL / WAIT / END entries.
// Optional RESETB pulse before the table runs is enabled by defining AD9361_SEQ_RESETB_EN.
module ad9361_spi_init_seq #(
    parameter int TBL_AW     = 8,
    parameter int XFER_TMO   = 4096,
    parameter int MAX_RETRY  = 255,
    parameter int POLL_GAP   = 1000,
    parameter int RESETB_CYC = 2000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Start,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error,
    output logic [TBL_AW-1:0] o_Err_Index,
    output logic [TBL_AW-1:0] o_Tbl_Addr,
    input  logic [31:0]       i_Tbl_Data,
    output logic [23:0]       o_TX_Word,
    output logic              o_TX_DV,
    input  logic              i_TX_Ready,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic [7:0]        o_RX_Last,
    output logic              o_RESETB,
    output logic [3:0]        o_Dbg_State
);

    localparam logic [1:0]  OP_END    = 2'b00;
    localparam logic [1:0]  OP_WRITE  = 2'b01;
    localparam logic [1:0]  OP_READ   = 2'b10;
    localparam logic [1:0]  OP_WAIT   = 2'b11;
    localparam logic [23:0] TMO_LAST  = 24'(XFER_TMO - 1);
    localparam logic [23:0] GAP_LOAD  = 24'(POLL_GAP);
    localparam logic [23:0] RST_LOAD  = 24'(RESETB_CYC);
    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_ROMWAIT  = 4'd2,
        S_DECODE   = 4'd3,
        S_ISSUE    = 4'd4,
        S_XFER     = 4'd5,
        S_CHECK    = 4'd6,
        S_DELAY    = 4'd7,
        S_NEXT     = 4'd8,
        S_DONE     = 4'd9,
        S_ERROR    = 4'd10
`ifdef AD9361_SEQ_RESETB_EN
        ,
        S_RSTPULSE = 4'd11,
        S_RSTWAIT  = 4'd12
`endif
    } state_t;

    state_t              state_q, state_nxt;
    logic [TBL_AW-1:0]   index_q, index_nxt;
    logic [31:0]         entry_q, entry_nxt;
    logic [23:0]         tx_word_q, tx_word_nxt;
    logic [23:0]         timer_q, timer_nxt;
    logic [7:0]          retry_q, retry_nxt, retry_inc;
    logic                done_q, done_nxt;
    logic                error_q, error_nxt;
    logic [TBL_AW-1:0]   err_index_q, err_index_nxt;
    logic [7:0]          rx_last_q, rx_last_nxt;
    logic                tx_dv;

    logic [1:0]  op;
    logic [11:0] addr;
    logic [7:0]  mask;
    logic [7:0]  data;
    logic [23:0] dly;
    logic        unused_rsvd;

    assign op          = entry_q[31:30];
    assign addr        = entry_q[27:16];
    assign mask        = entry_q[15:8];
    assign data        = entry_q[7:0];
    assign dly         = entry_q[23:0];
    assign unused_rsvd = ^entry_q[29:28];

    // Handshake: o_TX_DV is high only in ISSUE and only while i_TX_Ready is high; a word is
    // accepted on every clock where both are high, and i_RX_DV is honoured only in XFER.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state_q <= S_IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt     = state_q;
        index_nxt     = index_q;
        entry_nxt     = entry_q;
        tx_word_nxt   = tx_word_q;
        timer_nxt     = timer_q;
        retry_nxt     = retry_q;
        done_nxt      = done_q;
        error_nxt     = error_q;
        err_index_nxt = err_index_q;
        rx_last_nxt   = rx_last_q;
        tx_dv         = 1'b0;
        retry_inc     = retry_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                    index_nxt = '0;
                    retry_nxt = 8'd0;
                    timer_nxt = RST_LOAD;
`ifdef AD9361_SEQ_RESETB_EN
                    state_nxt = S_RSTPULSE;
`else
                    state_nxt = S_FETCH;
`endif
                end
            end
`ifdef AD9361_SEQ_RESETB_EN
            S_RSTPULSE: begin
                if (timer_q <= 24'd1) begin
                    timer_nxt = RST_LOAD;
                    state_nxt = S_RSTWAIT;
                end else begin
                    timer_nxt = timer_q - 24'd1;
                end
            end
            S_RSTWAIT: begin
                if (timer_q <= 24'd1) state_nxt = S_FETCH;
                else                  timer_nxt = timer_q - 24'd1;
            end
`endif
            S_FETCH:   state_nxt = S_ROMWAIT;
            S_ROMWAIT: begin
                entry_nxt = i_Tbl_Data;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_WRITE: begin
                        tx_word_nxt = {1'b1, 3'b000, addr, data};
                        state_nxt   = S_ISSUE;
                    end
                    OP_READ: begin
                        tx_word_nxt = {1'b0, 3'b000, addr, 8'h00};
                        state_nxt   = S_ISSUE;
                    end
                    OP_WAIT: begin
                        timer_nxt = dly;
                        state_nxt = S_DELAY;
                    end
                    default: state_nxt = S_DONE;
                endcase
            end
            S_ISSUE: begin
                if (i_TX_Ready) begin
                    tx_dv     = 1'b1;
                    timer_nxt = 24'd0;
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (i_RX_DV) begin
                    if (op == OP_READ) begin
                        rx_last_nxt = i_RX_Byte;
                        state_nxt   = S_CHECK;
                    end else begin
                        state_nxt = S_NEXT;
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_nxt = S_ERROR;
                end else begin
                    timer_nxt = timer_q + 24'd1;
                end
            end
            S_CHECK: begin
                if ((rx_last_q & mask) == (data & mask)) begin
                    state_nxt = S_NEXT;
                end else begin
                    retry_nxt = retry_inc;
                    if (retry_inc == RETRY_LIM) begin
                        state_nxt = S_ERROR;
                    end else begin
                        timer_nxt = GAP_LOAD;
                        state_nxt = S_DELAY;
                    end
                end
            end
            // A zero delay still spends one clock here.
            S_DELAY: begin
                if (timer_q <= 24'd1) state_nxt = (op == OP_READ) ? S_ISSUE : S_NEXT;
                else                  timer_nxt = timer_q - 24'd1;
            end
            S_NEXT: begin
                retry_nxt = 8'd0;
                if (&index_q) begin
                    state_nxt = S_DONE;
                end else begin
                    index_nxt = index_q + 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                error_nxt     = 1'b1;
                err_index_nxt = index_q;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            index_q     <= '0;
            entry_q     <= 32'd0;
            tx_word_q   <= 24'd0;
            timer_q     <= 24'd0;
            retry_q     <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            rx_last_q   <= 8'd0;
        end else begin
            index_q     <= index_nxt;
            entry_q     <= entry_nxt;
            tx_word_q   <= tx_word_nxt;
            timer_q     <= timer_nxt;
            retry_q     <= retry_nxt;
            done_q      <= done_nxt;
            error_q     <= error_nxt;
            err_index_q <= err_index_nxt;
            rx_last_q   <= rx_last_nxt;
        end
    end

    assign o_Busy      = (state_q != S_IDLE);
    assign o_Done      = done_q;
    assign o_Error     = error_q;
    assign o_Err_Index = err_index_q;
    assign o_Tbl_Addr  = index_q;
    assign o_TX_Word   = tx_word_q;
    assign o_TX_DV     = tx_dv;
    assign o_RX_Last   = rx_last_q;
    assign o_Dbg_State = state_q;
`ifdef AD9361_SEQ_RESETB_EN
    assign o_RESETB    = (state_q != S_RSTPULSE);
`else
    assign o_RESETB    = 1'b1;
`endif

endmodule

// File: tb/tb_ad9361_spi_init_seq.sv
// Directed bench for ad9361_spi_init_seq: ROM model, SPI master responder, expected-word queue.
// Builds with or without AD9361_SEQ_RESETB_EN.
module tb_ad9361_spi_init_seq;
    localparam int AW   = 4;
    localparam int TMO  = 64;
    localparam int RTRY = 3;
    localparam int GAP  = 20;
    localparam int RCYC = 10;
`ifdef AD9361_SEQ_RESETB_EN
    localparam int START_LAT = 4 + 2 * RCYC;
    localparam int RB_LOW    = RCYC;
`else
    localparam int START_LAT = 4;
    localparam int RB_LOW    = 0;
`endif

    logic          test_clk;
    logic          i_Rst_n;
    logic          i_Start;
    logic          busy, done, error;
    logic [AW-1:0] err_index, tbl_addr;
    logic [31:0]   tbl_data;
    logic [23:0]   tx_word;
    logic          tx_dv;
    logic          tx_ready;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [7:0]    rx_last;
    logic          resetb;
    logic [3:0]    dbg_state;

    ad9361_spi_init_seq #(
        .TBL_AW(AW), .XFER_TMO(TMO), .MAX_RETRY(RTRY), .POLL_GAP(GAP), .RESETB_CYC(RCYC)
    ) dut (
        .i_Clk(test_clk), .i_Rst_L(i_Rst_n), .i_Start(i_Start),
        .o_Busy(busy), .o_Done(done), .o_Error(error), .o_Err_Index(err_index),
        .o_Tbl_Addr(tbl_addr), .i_Tbl_Data(tbl_data),
        .o_TX_Word(tx_word), .o_TX_DV(tx_dv), .i_TX_Ready(tx_ready),
        .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .o_RX_Last(rx_last),
        .o_RESETB(resetb), .o_Dbg_State(dbg_state)
    );

    // clock / reset
    initial test_clk = 1'b0;
    always #5 test_clk = ~test_clk;

    int cyc = 0;
    always @(posedge test_clk) cyc <= cyc + 1;

    int rb_low = 0;
    always @(posedge test_clk) if (!resetb) rb_low = rb_low + 1;

    // synchronous table ROM: data valid one clock after the address
    logic [31:0] rom [0:(1<<AW)-1];
    always @(posedge test_clk) tbl_data <= rom[tbl_addr];

    // scoreboard state
    logic [23:0] exp_q[$];
    logic [7:0]  rx_q[$];
    int          tx_edges[$];
    int          rx_edges[$];
    int          tx_cnt;
    int          total = 0;
    int          bad = 0;
    int          start_edge;
    bit          rsp_en;
    int          rsp_lat = 3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SPI master responder
    initial begin
        logic [23:0] word_at_tx;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        forever begin
            @(negedge test_clk);
            if (tx_dv) begin
                tx_cnt++;
                tx_edges.push_back(cyc + 1);
                word_at_tx = tx_word;
                if (exp_q.size() > 0) check("tx_word", {8'h0, tx_word}, {8'h0, exp_q.pop_front()});
                if (rsp_en) begin
                    repeat (rsp_lat) @(negedge test_clk);
                    check("tx_hold", {8'h0, tx_word}, {8'h0, word_at_tx});
                    rx_byte = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
                    rx_dv   = 1'b1;
                    rx_edges.push_back(cyc + 1);
                    @(negedge test_clk);
                    rx_dv   = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic clear_tb();
        exp_q.delete();
        rx_q.delete();
        tx_edges.delete();
        rx_edges.delete();
        tx_cnt = 0;
        rsp_en = 1'b1;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 32'h0;
    endtask

    task automatic start_pulse();
        @(negedge test_clk);
        i_Start    = 1'b1;
        start_edge = cyc + 1;
        @(negedge test_clk);
        i_Start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge test_clk);
            n++;
        end
        check("busy_end", {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_tx(input int want);
        int n = 0;
        while (tx_cnt < want && n < 200) begin
            @(negedge test_clk);
            n++;
        end
        check("tx_seen", tx_cnt, want);
    endtask

    initial begin
        int d;
        int n;
        i_Rst_n  = 1'b0;
        i_Start  = 1'b0;
        tx_ready = 1'b1;
        clear_tb();
        repeat (3) @(negedge test_clk);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_error", {31'h0, error}, 0);
        check("rst_txdv", {31'h0, tx_dv}, 0);
        check("rst_word", {8'h0, tx_word}, 0);
        check("rst_rxlast", {24'h0, rx_last}, 0);
        check("rst_erridx", {28'h0, err_index}, 0);
        check("rst_addr", {28'h0, tbl_addr}, 0);
        check("rst_resetb", {31'h0, resetb}, 1);
        check("rst_state", {28'h0, dbg_state}, 0);
        i_Rst_n = 1'b1;
        repeat (2) @(negedge test_clk);

        // single WRITE then END; also RESETB low time and start latency
        clear_tb();
        rom[0] = 32'h43DF_0001;
        exp_q.push_back(24'h83DF01);
        rb_low = 0;
        start_pulse();
        wait_idle(300);
        check("t1_done", {31'h0, done}, 1);
        check("t1_error", {31'h0, error}, 0);
        check("t1_count", tx_cnt, 1);
        check("t1_latency", tx_edges[0] - start_edge, START_LAT);
        check("t1_resetb_low", rb_low, RB_LOW);

        // READ_POLL matching on the third read
        clear_tb();
        rom[0] = 32'h8247_0202;
        rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h02);
        repeat (3) exp_q.push_back(24'h024700);
        start_pulse();
        wait_idle(600);
        check("t2_done", {31'h0, done}, 1);
        check("t2_error", {31'h0, error}, 0);
        check("t2_count", tx_cnt, 3);
        check("t2_rxlast", {24'h0, rx_last}, 32'h02);
        check("t2_gap1", {31'h0, (tx_edges[1] - rx_edges[0]) >= GAP}, 1);
        check("t2_gap2", {31'h0, (tx_edges[2] - rx_edges[1]) >= GAP}, 1);

        // READ_POLL never matching at index 1: exactly RTRY reads, then error
        clear_tb();
        rom[0] = 32'h4100_0011;
        rom[1] = 32'h8101_FF5A;
        repeat (4) rx_q.push_back(8'h00);
        exp_q.push_back(24'h810011);
        repeat (RTRY) exp_q.push_back(24'h010100);
        start_pulse();
        wait_idle(600);
        check("t3_error", {31'h0, error}, 1);
        check("t3_done", {31'h0, done}, 0);
        check("t3_erridx", {28'h0, err_index}, 1);
        check("t3_count", tx_cnt, 1 + RTRY);
        check("t3_expq", exp_q.size(), 0);

        // no RX_DV: transfer timeout
        clear_tb();
        rsp_en = 1'b0;
        rom[0] = 32'h43DF_0001;
        exp_q.push_back(24'h83DF01);
        start_pulse();
        wait_tx(1);
        n = 0;
        while (!error && n < TMO + 50) begin
            @(negedge test_clk);
            n++;
        end
        d = cyc - tx_edges[0];
        check("t4_error", {31'h0, error}, 1);
        check("t4_tmo_time", {31'h0, (d >= TMO) && (d <= TMO + 3)}, 1);
        check("t4_busy", {31'h0, busy}, 0);
        check("t4_erridx", {28'h0, err_index}, 0);
        check("t4_done", {31'h0, done}, 0);

        // WRITE, WAIT 100, WRITE; start while busy ignored; restart clears done
        clear_tb();
        rom[0] = 32'h4010_00AA;
        rom[1] = 32'hC000_0064;
        rom[2] = 32'h4011_0055;
        exp_q.push_back(24'h8010AA);
        exp_q.push_back(24'h801155);
        start_pulse();
        repeat (20) @(negedge test_clk);
        start_pulse();
        wait_idle(600);
        check("t5_done", {31'h0, done}, 1);
        check("t5_count", tx_cnt, 2);
        d = tx_edges[1] - rx_edges[0];
        check("t5_wait_gap", {31'h0, (d >= 100) && (d <= 130)}, 1);
        exp_q.push_back(24'h8010AA);
        exp_q.push_back(24'h801155);
        start_pulse();
        check("t5_done_clr", {31'h0, done}, 0);
        check("t5_busy", {31'h0, busy}, 1);
        wait_idle(600);
        check("t5_redone", {31'h0, done}, 1);
        check("t5_recount", tx_cnt, 4);

        // implicit END after the last table entry
        clear_tb();
        for (int i = 0; i < (1 << AW) - 1; i++) rom[i] = 32'hC000_0000;
        rom[(1 << AW) - 1] = 32'h43FF_007E;
        exp_q.push_back(24'h83FF7E);
        start_pulse();
        wait_idle(600);
        check("t6_done", {31'h0, done}, 1);
        check("t6_count", tx_cnt, 1);
        check("t6_addr", {28'h0, tbl_addr}, (1 << AW) - 1);

        // reset asserted during XFER
        clear_tb();
        rsp_en = 1'b0;
        rom[0] = 32'h43DF_0001;
        exp_q.push_back(24'h83DF01);
        start_pulse();
        wait_tx(1);
        repeat (5) @(negedge test_clk);
        check("t7_in_xfer", {31'h0, busy}, 1);
        #2 i_Rst_n = 1'b0;
        #1;
        check("t7_busy", {31'h0, busy}, 0);
        check("t7_state", {28'h0, dbg_state}, 0);
        check("t7_word", {8'h0, tx_word}, 0);
        check("t7_resetb", {31'h0, resetb}, 1);
        check("t7_done", {31'h0, done}, 0);
        @(negedge test_clk);
        i_Rst_n = 1'b1;

        // reset asserted while o_TX_DV is high in ISSUE
        clear_tb();
        tx_ready = 1'b0;
        rom[0] = 32'h43DF_0001;
        start_pulse();
        repeat (START_LAT + 2) @(negedge test_clk);
        #2 tx_ready = 1'b1;
        #1;
        check("t8_txdv_on", {31'h0, tx_dv}, 1);
        i_Rst_n = 1'b0;
        #1;
        check("t8_txdv_off", {31'h0, tx_dv}, 0);
        check("t8_busy", {31'h0, busy}, 0);
        @(negedge test_clk);
        i_Rst_n = 1'b1;
        repeat (3) @(negedge test_clk);
        check("t8_idle", {31'h0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
